// File: rtl/niu32_dmem_arbiter_if.sv
// Two-requester data-memory bus for the Niu32 dmem arbiter: port 0 is the CPU MAR/MDR path,
// and port 1 is the debug/DMA loader.
interface niu32_dmem_arbiter_if #(
  parameter int WORD_SIZE = 32
);
  logic                 req0, req1;
  logic                 we0, we1;
  logic [WORD_SIZE-1:0] addr0, addr1;
  logic [WORD_SIZE-1:0] wdata0, wdata1;
  logic                 ack0, ack1;
  logic                 rvalid0, rvalid1;
  logic [WORD_SIZE-1:0] rdata0, rdata1;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  ack0, ack1, rvalid0, rvalid1, rdata0, rdata1
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output ack0, ack1, rvalid0, rvalid1, rdata0, rdata1
  );
endinterface

// File: rtl/niu32_dmem_arbiter.sv
// Round-robin arbiter sharing the Niu32 dmem and board MMIO between two requesters.
// Define NIU32_MMIO_READBACK_EN to make HEX/LEDR/LEDG registers readable (otherwise they read 0).
module niu32_dmem_arbiter #(
  parameter int                   WORD_SIZE       = 32,
  parameter int                   DMEM_WORDS      = 2048,
  parameter int                   MEM_ADDR_BITS   = 13,
  parameter int                   MEM_WORD_OFFSET = 2,
  parameter logic [WORD_SIZE-1:0] ADDR_HEX        = 32'hFFFF0000,
  parameter logic [WORD_SIZE-1:0] ADDR_LEDR       = 32'hFFFF0020,
  parameter logic [WORD_SIZE-1:0] ADDR_LEDG       = 32'hFFFF0040,
  parameter logic [WORD_SIZE-1:0] ADDR_KEY        = 32'hFFFF0100,
  parameter logic [WORD_SIZE-1:0] ADDR_SWITCH     = 32'hFFFF0120
) (
  input  logic                 clk,
  input  logic                 reset,
  niu32_dmem_arbiter_if.slave  bus,
  input  logic [3:0]           KEY,
  input  logic [9:0]           SWITCH,
  output logic [15:0]          HEXout,
  output logic [9:0]           LEDRout,
  output logic [7:0]           LEDGout
);
  localparam int IDX_W = MEM_ADDR_BITS - MEM_WORD_OFFSET;

  typedef enum logic [1:0] {IDLE, GRANT, RESP} state_t;

  state_t               state;
  logic                 sel;
  logic                 rr_last;
  logic                 ack0_r, ack1_r;
  logic                 pick;
  logic                 g_we;
  logic [WORD_SIZE-1:0] g_addr, g_wdata;
  logic [IDX_W-1:0]     g_idx;
  logic                 hit_hex, hit_ledr, hit_ledg, hit_key, hit_sw, hit_dmem;
  logic [WORD_SIZE-1:0] rd_val;
  logic [WORD_SIZE-1:0] mem [DMEM_WORDS];

  // On contention the port that did not win last time goes next.
  assign pick = (bus.req0 && bus.req1) ? ~rr_last : bus.req1;

  assign g_we    = sel ? bus.we1    : bus.we0;
  assign g_addr  = sel ? bus.addr1  : bus.addr0;
  assign g_wdata = sel ? bus.wdata1 : bus.wdata0;
  assign g_idx   = g_addr[MEM_ADDR_BITS-1:MEM_WORD_OFFSET];

  assign hit_hex  = (g_addr == ADDR_HEX);
  assign hit_ledr = (g_addr == ADDR_LEDR);
  assign hit_ledg = (g_addr == ADDR_LEDG);
  assign hit_key  = (g_addr == ADDR_KEY);
  assign hit_sw   = (g_addr == ADDR_SWITCH);
  assign hit_dmem = ~(hit_hex | hit_ledr | hit_ledg | hit_key | hit_sw);

  always_comb begin
    rd_val = '0;
    if (hit_key) begin
      rd_val = WORD_SIZE'(KEY);
    end else if (hit_sw) begin
      rd_val = WORD_SIZE'(SWITCH);
    end else if (hit_dmem) begin
      rd_val = mem[g_idx];
    end else begin
`ifdef NIU32_MMIO_READBACK_EN
      if (hit_hex)       rd_val = WORD_SIZE'(HEXout);
      else if (hit_ledr) rd_val = WORD_SIZE'(LEDRout);
      else               rd_val = WORD_SIZE'(LEDGout);
`endif
    end
  end

  // A reset landing in the GRANT cycle must suppress the ack that is already registered.
  assign bus.ack0 = ack0_r & ~reset;
  assign bus.ack1 = ack1_r & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      sel         <= 1'b0;
      rr_last     <= 1'b1;
      ack0_r      <= 1'b0;
      ack1_r      <= 1'b0;
      bus.rvalid0 <= 1'b0;
      bus.rvalid1 <= 1'b0;
      bus.rdata0  <= '0;
      bus.rdata1  <= '0;
      HEXout      <= '0;
      LEDRout     <= '0;
      LEDGout     <= '0;
    end else begin
      ack0_r      <= 1'b0;
      ack1_r      <= 1'b0;
      bus.rvalid0 <= 1'b0;
      bus.rvalid1 <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            sel     <= pick;
            rr_last <= pick;
            ack0_r  <= ~pick;
            ack1_r  <= pick;
            state   <= GRANT;
          end
        end
        GRANT: begin
          if (g_we) begin
            if (hit_hex)  HEXout  <= g_wdata[15:0];
            if (hit_ledr) LEDRout <= g_wdata[9:0];
            if (hit_ledg) LEDGout <= g_wdata[7:0];
            state <= IDLE;
          end else begin
            if (sel) begin
              bus.rvalid1 <= 1'b1;
              bus.rdata1  <= rd_val;
            end else begin
              bus.rvalid0 <= 1'b1;
              bus.rdata0  <= rd_val;
            end
            state <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && state == GRANT && g_we && hit_dmem) mem[g_idx] <= g_wdata;
  end
endmodule
